pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside the forwarding hazard unit and covers the hazards forwarding cannot resolve.
- Load-use: one bubble.
- Taken branch resolved in EX: flush of the wrong-path instructions.
- Multi-cycle MULT/DIV unit: sequenced by an internal busy FSM; HI/LO readers and new MULT/DIV are held until the result is ready.
- Also keeps stall and flush performance counters.

Parameters:
MULT_LAT, 4, cycles MULT occupies the HI/LO unit (>=1).
DIV_LAT, 16, cycles DIV occupies the HI/LO unit (>=1).
CNT_W, 32, width of performance counters.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
IDRs  in  5  rs of instruction in ID
IDRt  in  5  rt of instruction in ID
IDUsesRs  in  1  ID instruction reads rs
IDUsesRt  in  1  ID instruction reads rt
IDIsMult  in  1  ID instruction is MULT/MULTU
IDIsDiv  in  1  ID instruction is DIV/DIVU
IDReadsHiLo  in  1  ID instruction is MFHI/MFLO
EXMemRead  in  1  EX instruction is a load
EXRd  in  5  destination register of EX instruction
EXBranchTaken  in  1  branch/jump in EX redirects PC this cycle
StallPC  out  1  hold PC
StallIFID  out  1  hold IF/ID register
FlushIFID  out  1  clear IF/ID to NOP
FlushIDEX  out  1  load bubble into ID/EX
MDStart  out  1  launch MULT/DIV unit (ID instruction advancing)
MDBusy  out  1  MULT/DIV unit occupied (registered)
MDDone  out  1  one-cycle pulse, last busy cycle
StallCount  out  CNT_W  cycles with StallPC=1
FlushCount  out  CNT_W  cycles with FlushIFID=1

Behaviour:
- Reset, checked on the CLK edge with RST=1:
  - FSM goes to IDLE and the counter to 0.
  - StallCount and FlushCount go to 0.
  - MDBusy and MDDone read 0 from the following cycle.
  - While RST=1, every combinational output (stall, flush, MDStart) is forced to 0.
- Load-use hazard, combinational:
  - LU = EXMemRead & EXRd!=0 & ((IDUsesRs & IDRs==EXRd) | (IDUsesRt & IDRt==EXRd)).
- Mul/div hazard, combinational:
  - MDH = MDBusy & (IDReadsHiLo | IDIsMult | IDIsDiv).
  - MDH stays asserted through the MDDone cycle. The ID instruction advances on the first cycle after busy ends.
- Priority:
  1. EXBranchTaken: FlushIFID=1, FlushIDEX=1, StallPC=StallIFID=0, MDStart=0. The wrong-path ID instruction is discarded.
  2. LU or MDH: StallPC=1, StallIFID=1, FlushIDEX=1, FlushIFID=0.
  3. Otherwise all stall/flush outputs are 0.
- MDStart = (IDIsMult|IDIsDiv) & !stall & !EXBranchTaken. It is never asserted while MDBusy=1, because MDH stalls first.
- Busy FSM, states IDLE and BUSY:
  - IDLE→BUSY on MDStart. The counter loads MULT_LAT (IDIsMult) or DIV_LAT (IDIsDiv).
  - In BUSY the counter decrements each cycle. MDDone=1 when the counter==1.
  - On the next edge after MDDone the FSM returns to IDLE with the counter at 0.
  - MDBusy=1 exactly in BUSY, for LAT cycles starting the cycle after MDStart.
  - Back-to-back MULT: the second one stalls until IDLE, then starts. There is no overlap.
- Counter width is clog2(max(MULT_LAT,DIV_LAT)+1).
- Performance counters increment on the respective signal and saturate at all-ones; they do not wrap.
- Reset mid-BUSY aborts the operation immediately. No MDDone pulse is produced.
- RegWrite-based forwarding conditions are not evaluated here.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state encoding (MD_IDLE, MD_BUSY);
  - the default latency constants;
  - the counter-width function.
- One natural sub-module, md_busy_tracker, owns the FSM, the latency counter, MDBusy and MDDone. The top level keeps the hazard equations, priority and perf counters.

Test Plan:
- lw $8 in EX (EXMemRead=1, EXRd=8), ID add reading rs=8 → exactly one cycle of StallPC=StallIFID=FlushIDEX=1; StallCount 0→1. Repeat with EXRd=0 → no stall.
- Load-use condition together with EXBranchTaken=1 → FlushIFID=FlushIDEX=1, StallPC=0; FlushCount +1, StallCount unchanged.
- MULT in ID at cycle t (MULT_LAT=4) → MDStart=1 at t; MDBusy=1 for t+1..t+4 with MDDone at t+4. MFHI in ID at t+1 → StallPC=1 for cycles t+1..t+4; it advances at t+5.
- DIV (DIV_LAT=16) followed by MULT → MULT stalls 16 cycles; MDStart for MULT at the first cycle after busy ends; MDBusy then runs 4 cycles.
- RST=1 at the third BUSY cycle of a DIV → next cycle MDBusy=0, MDDone never pulses, counters=0; MFHI then proceeds without stall.
- MULT in ID with EXBranchTaken=1 → MDStart=0, FSM stays IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam int DEF_MULT_LAT = 4;
   localparam int DEF_DIV_LAT  = 16;

   // Latency counter must hold the larger of the two latencies.
   function automatic int md_cnt_width(input int mult_lat, input int div_lat);
      int lat_max;
      lat_max = (mult_lat > div_lat) ? mult_lat : div_lat;
      return $clog2(lat_max + 1);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_md_busy_tracker.sv
// Occupancy tracker for the multi-cycle MULT/DIV unit: IDLE/BUSY FSM with a
// latency down-counter; busy and done are registered.
module md_busy_tracker
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic is_mult,
   output logic busy,
   output logic done
);

   // state   | meaning
   // MD_IDLE | unit free, waiting for start
   // MD_BUSY | operation in flight, cnt = cycles left including this one

   localparam int CW = md_cnt_width(MULT_LAT, DIV_LAT);
   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TWO  = CW'(2);

   md_state_e     state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  state <= MD_BUSY;
                  busy  <= 1'b1;
                  cnt   <= is_mult ? MULT_CNT : DIV_CNT;
                  // A one-cycle latency makes the first busy cycle also the last.
                  done  <= is_mult ? (MULT_CNT == CNT_ONE) : (DIV_CNT == CNT_ONE);
               end
            end
            MD_BUSY: begin
               if (cnt == CNT_ONE) begin
                  state <= MD_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else begin
                  cnt  <= cnt - CNT_ONE;
                  done <= (cnt == CNT_TWO);
               end
            end
            default: begin
               state <= MD_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use and MULT/DIV
// hazards, taken-branch flush, and saturating stall/flush counters.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       IDRs,
   input  logic [4:0]       IDRt,
   input  logic             IDUsesRs,
   input  logic             IDUsesRt,
   input  logic             IDIsMult,
   input  logic             IDIsDiv,
   input  logic             IDReadsHiLo,
   input  logic             EXMemRead,
   input  logic [4:0]       EXRd,
   input  logic             EXBranchTaken,
   output logic             StallPC,
   output logic             StallIFID,
   output logic             FlushIFID,
   output logic             FlushIDEX,
   output logic             MDStart,
   output logic             MDBusy,
   output logic             MDDone,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   logic load_use;
   logic md_hazard;
   logic stall;

   assign load_use  = EXMemRead && (EXRd != 5'd0) &&
                      ((IDUsesRs && (IDRs == EXRd)) || (IDUsesRt && (IDRt == EXRd)));
   assign md_hazard = MDBusy && (IDReadsHiLo || IDIsMult || IDIsDiv);
   assign stall     = load_use || md_hazard;

   // Branch flush outranks any stall: the ID instruction is wrong-path anyway.
   always_comb begin
      StallPC   = 1'b0;
      StallIFID = 1'b0;
      FlushIFID = 1'b0;
      FlushIDEX = 1'b0;
      MDStart   = 1'b0;
      if (!RST) begin
         if (EXBranchTaken) begin
            FlushIFID = 1'b1;
            FlushIDEX = 1'b1;
         end else if (stall) begin
            StallPC   = 1'b1;
            StallIFID = 1'b1;
            FlushIDEX = 1'b1;
         end else begin
            MDStart = IDIsMult || IDIsDiv;
         end
      end
   end

   md_busy_tracker #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy (
      .clk     (CLK),
      .rst     (RST),
      .start   (MDStart),
      .is_mult (IDIsMult),
      .busy    (MDBusy),
      .done    (MDDone)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallPC && (StallCount != '1))
            StallCount <= StallCount + CNT_W'(1);
         if (FlushIFID && (FlushCount != '1))
            FlushCount <= FlushCount + CNT_W'(1);
      end
   end

endmodule
